// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared register-map constants and types for the machine timer block
//
// Purpose: word indices of the timer register window, bit positions inside the
//          ctrl and status registers, and the packed ctrl register layout.
// Ports:   none (package).

package core_pkg;

  // Word index inside the 32-byte window (byte offset >> 2).
  localparam logic [2:0] TMR_OFF_MTIME_LO    = 3'd0;  // 0x00
  localparam logic [2:0] TMR_OFF_MTIME_HI    = 3'd1;  // 0x04
  localparam logic [2:0] TMR_OFF_MTIMECMP_LO = 3'd2;  // 0x08
  localparam logic [2:0] TMR_OFF_MTIMECMP_HI = 3'd3;  // 0x0C
  localparam logic [2:0] TMR_OFF_CTRL        = 3'd4;  // 0x10
  localparam logic [2:0] TMR_OFF_STATUS      = 3'd5;  // 0x14

  localparam int TMR_PRESC_W = 8;

  localparam int CTRL_TEN_BIT       = 0;
  localparam int CTRL_PRESC_LSB     = 8;
  localparam int STATUS_TPEND_BIT   = 0;
  localparam int STATUS_EPEND_BIT   = 1;

  typedef struct packed {
    logic [TMR_PRESC_W-1:0] presc;
    logic                   ten;
  } tmr_ctrl_t;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchroniser followed by a rising-edge detector
//
// Purpose: brings an asynchronous interrupt line into the clk domain and emits a
//          one-cycle pulse for each rising edge seen after synchronisation.
// Ports:
//   clk   in  1  core clock
//   rst   in  1  asynchronous reset, active-low
//   din   in  1  asynchronous input line
//   rise  out 1  one-cycle pulse, combinational from flops only

module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // All three flops clear on reset, so a line already high at release shows
  // up as a single fresh edge instead of being lost or replayed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - memory-mapped machine timer and interrupt source
//
// Purpose: 64-bit mtime/mtimecmp with prescaled tick, synchronised external
//          interrupt with pending bit, and the trap request for the CSR file.
// Ports:
//   clk        in  1   core clock
//   rst        in  1   asynchronous reset, active-low
//   addr       in  32  LSU byte address (addr[1:0] ignored)
//   wdata      in  32  store data
//   wr_en      in  1   store strobe
//   rd_en      in  1   load strobe
//   rdata      out 32  load data (combinational, 0 when not selected)
//   sel        out 1   address inside the 32-byte window
//   ext_irq_in in  1   asynchronous external interrupt line
//   irq_ack    in  1   trap-entry pulse, clears external pending
//   timer_irq  out 1   registered timer interrupt
//   ext_irq    out 1   registered external pending bit
//   trap_req   out 1   timer_irq | ext_irq

module timer_irq_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          PRESCALE_W = TMR_PRESC_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        sel,
  input  logic        ext_irq_in,
  input  logic        irq_ack,
  output logic        timer_irq,
  output logic        ext_irq,
  output logic        trap_req
);

  tmr_ctrl_t             ctrl;
  logic [PRESCALE_W-1:0] pcnt;
  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic                  epend;
  logic                  ext_rise;

  logic [2:0] widx;
  logic       wr_hit;
  logic       rd_hit;
  logic       wr_mtime_lo;
  logic       wr_mtime_hi;
  logic       wr_cmp_lo;
  logic       wr_cmp_hi;
  logic       wr_ctrl;
  logic       wr_status;
  logic       tick;
  logic       unused_addr_bits;

  // ---------------------------------------------------------------- decode
  assign sel    = (addr[31:5] == BASE_ADDR[31:5]);
  assign widx   = addr[4:2];
  assign wr_hit = wr_en & sel;
  assign rd_hit = rd_en & sel;

  assign wr_mtime_lo = wr_hit && (widx == TMR_OFF_MTIME_LO);
  assign wr_mtime_hi = wr_hit && (widx == TMR_OFF_MTIME_HI);
  assign wr_cmp_lo   = wr_hit && (widx == TMR_OFF_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_hit && (widx == TMR_OFF_MTIMECMP_HI);
  assign wr_ctrl     = wr_hit && (widx == TMR_OFF_CTRL);
  assign wr_status   = wr_hit && (widx == TMR_OFF_STATUS);

  assign unused_addr_bits = ^addr[1:0];

  // -------------------------------------------------------------- prescaler
  // Tick fires on the cycle pcnt sits at presc; the counter then wraps to 0.
  assign tick = ctrl.ten && (pcnt == ctrl.presc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (wr_ctrl || !ctrl.ten || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      ctrl.ten   <= wdata[CTRL_TEN_BIT];
      ctrl.presc <= wdata[CTRL_PRESC_LSB +: TMR_PRESC_W];
    end
  end

  // ------------------------------------------------------------------ mtime
  // A half-word write replaces the increment for the whole cycle; the other
  // half is left alone, so no carry crosses into or out of the written half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime <= '0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= wdata;
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= '1;
    end else if (wr_cmp_lo) begin
      mtimecmp[31:0] <= wdata;
    end else if (wr_cmp_hi) begin
      mtimecmp[63:32] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= ctrl.ten && (mtime >= mtimecmp);
    end
  end

  // ------------------------------------------------------- external line
  irq_sync_edge u_ext_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ext_irq_in),
    .rise (ext_rise)
  );

  // Set beats clear so an edge arriving with an ack is never dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epend <= 1'b0;
    end else if (ext_rise) begin
      epend <= 1'b1;
    end else if (irq_ack || (wr_status && wdata[STATUS_EPEND_BIT])) begin
      epend <= 1'b0;
    end
  end

  assign ext_irq  = epend;
  assign trap_req = timer_irq | epend;

  // ------------------------------------------------------------ read mux
  always_comb begin
    rdata = 32'h0;
    if (rd_hit) begin
      case (widx)
        TMR_OFF_MTIME_LO:    rdata = mtime[31:0];
        TMR_OFF_MTIME_HI:    rdata = mtime[63:32];
        TMR_OFF_MTIMECMP_LO: rdata = mtimecmp[31:0];
        TMR_OFF_MTIMECMP_HI: rdata = mtimecmp[63:32];
        TMR_OFF_CTRL: begin
          rdata[CTRL_TEN_BIT]                       = ctrl.ten;
          rdata[CTRL_PRESC_LSB +: TMR_PRESC_W]      = ctrl.presc;
        end
        TMR_OFF_STATUS: begin
          rdata[STATUS_TPEND_BIT] = timer_irq;
          rdata[STATUS_EPEND_BIT] = epend;
        end
        default:             rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - randomized self-checking bench for timer_irq_ctrl

module tb_timer_irq_ctrl;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] rdata;
  logic        sel;
  logic        ext_irq_in = 1'b0;
  logic        irq_ack = 1'b0;
  logic        timer_irq;
  logic        ext_irq;
  logic        trap_req;

  always #5 clk = ~clk;

  timer_irq_ctrl #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .rdata      (rdata),
    .sel        (sel),
    .ext_irq_in (ext_irq_in),
    .irq_ack    (irq_ack),
    .timer_irq  (timer_irq),
    .ext_irq    (ext_irq),
    .trap_req   (trap_req)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  bit          m_ten;
  logic [7:0]  m_presc;
  int          m_pcnt;
  bit          m_epend;
  bit          m_tirq;
  bit          xs[$];   // ext_irq_in as sampled at each clock edge since reset

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd31);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (word_of(a))
      0: return m_time[31:0];
      1: return m_time[63:32];
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return 32'(m_presc) * 256 + 32'(m_ten);
      5: return 32'(m_epend) * 2 + 32'(m_tirq);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_time  = 64'd0;
    m_cmp   = {64{1'b1}};
    m_ten   = 1'b0;
    m_presc = 8'd0;
    m_pcnt  = 0;
    m_epend = 1'b0;
    m_tirq  = 1'b0;
    xs.delete();
    repeat (3) xs.push_back(1'b0);
  endtask

  task automatic model_clock(input logic [31:0] a, input logic [31:0] wd, input bit we,
                             input bit xin, input bit ack);
    bit          wr;
    int          w;
    int          period;
    bit          tick;
    bit          seen_edge;
    bit          next_tirq;
    logic [63:0] next_time;
    wr        = we && in_win(a);
    w         = word_of(a);
    period    = int'(m_presc) + 1;
    tick      = m_ten && ((m_pcnt + 1) % period == 0);
    next_tirq = m_ten && (m_time >= m_cmp);
    // an edge is seen two samples back: high then, low the sample before
    seen_edge = xs[xs.size()-2] && !xs[xs.size()-3];

    next_time = m_time;
    if (wr && w == 0)      next_time = {m_time[63:32], wd};
    else if (wr && w == 1) next_time = {wd, m_time[31:0]};
    else if (tick)         next_time = m_time + 64'd1;

    if (wr && w == 4 || !m_ten) m_pcnt = 0;
    else                        m_pcnt = (m_pcnt + 1) % period;

    if (wr && w == 2) m_cmp = {m_cmp[63:32], wd};
    if (wr && w == 3) m_cmp = {wd, m_cmp[31:0]};
    if (wr && w == 4) begin
      m_ten   = wd[0];
      m_presc = wd[15:8];
    end

    if (seen_edge)                             m_epend = 1'b1;
    else if (ack || (wr && w == 5 && wd[1]))   m_epend = 1'b0;

    xs.push_back(xin);
    void'(xs.pop_front());
    m_time = next_time;
    m_tirq = next_tirq;
  endtask

  // ------------------------------------------------------------- stimulus
  bit xl = 1'b0;   // current ext_irq_in level used by helper tasks

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input bit we, input bit re,
                      input bit xin, input bit ack, output logic [31:0] got);
    check("timer_irq", timer_irq, m_tirq);
    check("ext_irq", ext_irq, m_epend);
    check("trap_req", trap_req, m_tirq | m_epend);
    addr = a; wdata = wd; wr_en = we; rd_en = re; ext_irq_in = xin; irq_ack = ack;
    #1;
    got = rdata;
    check("sel", sel, in_win(a));
    check("rdata", rdata, (re && in_win(a)) ? m_read(a) : 32'h0);
    @(posedge clk);
    model_clock(a, wd, we, xin, ack);
    @(negedge clk);
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    logic [31:0] g;
    step(BASE + 32'(off), d, 1'b1, 1'b0, xl, 1'b0, g);
  endtask

  task automatic rd(input int off, output logic [31:0] g);
    step(BASE + 32'(off), 32'h0, 1'b0, 1'b1, xl, 1'b0, g);
  endtask

  task automatic idle(input int n);
    logic [31:0] g;
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 1'b0, xl, 1'b0, g);
  endtask

  task automatic ack_only();
    logic [31:0] g;
    step(32'h0, 32'h0, 1'b0, 1'b0, xl, 1'b1, g);
  endtask

  task automatic mid_reset();
    rst = 1'b0;
    #1;
    check("rst_timer_irq", timer_irq, 1'b0);
    check("rst_ext_irq", ext_irq, 1'b0);
    check("rst_trap_req", trap_req, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  logic [31:0] g;

  initial begin
    // reset held with the external line high
    rst = 1'b0; ext_irq_in = 1'b1; addr = BASE + 32'h8; rd_en = 1'b1;
    @(negedge clk); @(negedge clk);
    check("reset_timer_irq", timer_irq, 1'b0);
    check("reset_ext_irq", ext_irq, 1'b0);
    check("reset_trap_req", trap_req, 1'b0);
    check("reset_cmp_lo", rdata, 32'hFFFF_FFFF);
    rd_en = 1'b0;
    model_reset();
    rst = 1'b1;
    xl  = 1'b1;   // line high at release must count as one edge

    // prescaler: presc=3, ten=1
    wr(32'h10, 32'h0000_0301);
    idle(40);
    rd(32'h00, g);
    check("presc_mtime_lo", g, 32'd10);
    wr(32'h10, 32'h0);
    idle(5);
    rd(32'h00, g);
    check("frozen_mtime_lo", g, 32'd10);

    // compare
    wr(32'h00, 32'h0); wr(32'h04, 32'h0);
    wr(32'h0C, 32'h0); wr(32'h08, 32'd20);
    wr(32'h10, 32'h1);
    idle(25);
    wr(32'h08, 32'd100);
    idle(2);
    check("cmp_fall", timer_irq, 1'b0);

    // wrap and missing carry
    wr(32'h10, 32'h0);
    wr(32'h04, 32'hFFFF_FFFF); wr(32'h00, 32'hFFFF_FFFE);
    wr(32'h10, 32'h1);
    idle(2);
    rd(32'h00, g); check("wrap_lo", g, 32'h0);
    rd(32'h04, g); check("wrap_hi", g, 32'h0);
    wr(32'h10, 32'h0);
    wr(32'h04, 32'h0); wr(32'h00, 32'hFFFF_FFFF);
    wr(32'h10, 32'h1);
    rd(32'h04, g); check("carry_hi_before", g, 32'h0);
    rd(32'h00, g); check("carry_lo", g, 32'h0);
    rd(32'h04, g); check("carry_hi", g, 32'h1);

    // external interrupt path
    xl = 1'b0;
    idle(3);
    ack_only();
    idle(1);
    check("ext_cleared", ext_irq, 1'b0);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, g);
    idle(1);
    check("ext_early", ext_irq, 1'b0);
    idle(1);
    check("ext_3cyc", ext_irq, 1'b1);
    idle(4);
    check("ext_hold", ext_irq, 1'b1);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, g);
    idle(1);
    ack_only();
    check("ack_vs_edge", ext_irq, 1'b1);
    ack_only();
    check("lone_ack", ext_irq, 1'b0);

    // bus corners and status write-one-to-clear
    rd(32'h18, g); check("rd_0x18", g, 32'h0);
    step(BASE + 32'h20, 32'h0, 1'b0, 1'b1, xl, 1'b0, g); check("rd_outside", g, 32'h0);
    step(BASE - 32'h4, 32'hFFFF_FFFF, 1'b1, 1'b1, xl, 1'b0, g); check("rd_below", g, 32'h0);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, g);
    idle(3);
    wr(32'h14, 32'h2);
    check("w1c_epend", ext_irq, 1'b0);
    wr(32'h0C, 32'h0); wr(32'h08, 32'h0);
    idle(2);
    wr(32'h14, 32'h1);
    check("w1c_tpend_kept", timer_irq, 1'b1);
    step(BASE + 32'h10, 32'h0000_0201, 1'b1, 1'b1, xl, 1'b0, g);
    check("rw_same_cycle_old", g, 32'h0000_0001);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int          r;
      int          w;
      logic [31:0] a;
      logic [31:0] d;
      bit          we;
      bit          re;
      bit          ack;
      if (c == 700) mid_reset();
      r = $urandom_range(0, 99);
      w = $urandom_range(0, 8);
      if (w == 8) a = ($urandom_range(0, 1) == 1) ? BASE + 32'h20 + 32'($urandom_range(0, 60))
                                                   : BASE - 32'h4;
      else        a = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
      d = $urandom;
      case (w)
        2: d = m_time[31:0] + 32'($urandom_range(0, 40));
        3: d = m_time[63:32];
        4: d = (d & 32'hFFFF_00FE) | (32'($urandom_range(0, 3)) << 8)
               | 32'($urandom_range(0, 3) != 0);
        default: ;
      endcase
      we  = (r < 10);
      re  = (r >= 5) && (r < 45);
      if ($urandom_range(0, 9) == 0) xl = ~xl;
      ack = ($urandom_range(0, 9) == 0);
      step(a, d, we, re, xl, ack, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
